// File: rtl/invsqrt_result_fifo_if.sv
// invsqrt_result_fifo_if: result/consumer bundle for invsqrt_result_fifo; out_class present with INVSQRT_FIFO_CLASS_EN
interface invsqrt_result_fifo_if #(parameter int DEPTH = 16, parameter int CNT_W = 16);
  logic ce;
  logic [31:0] DataIn;
  logic DataValid;
  logic clr_ovf;
  logic [31:0] out_data;
  logic out_valid;
  logic out_ready;
  logic [$clog2(DEPTH):0] level;
  logic overflow;
  logic [CNT_W-1:0] sample_cnt;
`ifdef INVSQRT_FIFO_CLASS_EN
  logic [1:0] out_class;
  modport master(
    output ce, DataIn, DataValid, clr_ovf, out_ready,
    input  out_data, out_valid, level, overflow, sample_cnt, out_class
  );
  modport slave(
    input  ce, DataIn, DataValid, clr_ovf, out_ready,
    output out_data, out_valid, level, overflow, sample_cnt, out_class
  );
`else
  modport master(
    output ce, DataIn, DataValid, clr_ovf, out_ready,
    input  out_data, out_valid, level, overflow, sample_cnt
  );
  modport slave(
    input  ce, DataIn, DataValid, clr_ovf, out_ready,
    output out_data, out_valid, level, overflow, sample_cnt
  );
`endif
endinterface

// File: rtl/invsqrt_result_fifo.sv
// invsqrt_result_fifo: FWFT buffer for InvertSQRoot results; INVSQRT_FIFO_CLASS_EN adds a per-entry IEEE class tag
module invsqrt_result_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  invsqrt_result_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef INVSQRT_FIFO_CLASS_EN
  localparam int EW = 34;
  function automatic logic [1:0] classify(input logic [31:0] d);
    return (d[30:23] == 8'hFF) ? ((d[22:0] == '0) ? 2'b10 : 2'b11) : ((d[30:0] == '0) ? 2'b01 : 2'b00);
  endfunction
`else
  localparam int EW = 32;
`endif
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head, head_nxt, din;
  logic [AW-1:0] rd_ptr, rd_nxt, wr_ptr;
  logic [LW-1:0] level;
  logic [CNT_W-1:0] cnt;
  logic ovf, wr_req, rd, full, wr, drop, last;
`ifdef INVSQRT_FIFO_CLASS_EN
  assign din = {classify(bus.DataIn), bus.DataIn};
  assign bus.out_class = head[33:32];
`else
  assign din = bus.DataIn;
`endif
  // the head register holds the next word to present, so out_data keeps its last value once empty
  always_comb begin
    wr_req = bus.ce & bus.DataValid;
    rd = (level != '0) & bus.out_ready;
    full = level == LW'(DEPTH);
    wr = wr_req & (~full | rd);
    drop = wr_req & full & ~rd;
    last = (level == '0) | (rd & (level == LW'(1)));
    rd_nxt = rd_ptr + AW'(1);
    head_nxt = last ? (wr ? din : head) : (rd ? mem[rd_nxt] : head);
  end
  // pointers, occupancy, head, sticky overflow and sample counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level <= '0;
      head <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_nxt;
      if (wr) cnt <= cnt + CNT_W'(1);
      level <= level + LW'(wr) - LW'(rd);
      head <= head_nxt;
      ovf <= drop | (ovf & ~bus.clr_ovf);
    end
  end
  // storage has no reset; writes are blocked during reset
  always_ff @(posedge clk) begin
    if (rst && wr) mem[wr_ptr] <= din;
  end
  assign bus.out_data = head[31:0];
  assign bus.out_valid = level != '0;
  assign bus.level = level;
  assign bus.overflow = ovf;
  assign bus.sample_cnt = cnt;
endmodule

// File: tb/tb_invsqrt_result_fifo.sv
// tb_invsqrt_result_fifo: scoreboard bench for invsqrt_result_fifo (INVSQRT_FIFO_CLASS_EN adds class checks)
module tb_invsqrt_result_fifo;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [33:0] q[$];
  logic exp_ovf = 1'b0;
  logic [CNT_W-1:0] exp_cnt = '0;

  invsqrt_result_fifo_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus();
  invsqrt_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut(.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [1:0] cls_of(input logic [31:0] d);
    logic [7:0] e;
    logic [22:0] m;
    e = d[30:23];
    m = d[22:0];
    if (e == 8'hFF && m != 0) return 2'b11;
    if (e == 8'hFF) return 2'b10;
    if (e == 8'h00 && m == 0) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic rd, drop;
    drop = 1'b0;
    if (!rst) begin
      q.delete();
      exp_ovf = 1'b0;
      exp_cnt = '0;
    end else begin
      rd = bus.out_valid && bus.out_ready;
      if (rd && q.size() > 0) begin
        chk("read_data", 34'(bus.out_data), 34'(q[0][31:0]));
        void'(q.pop_front());
      end
      if (bus.ce && bus.DataValid) begin
        if (q.size() < DEPTH) begin
          q.push_back({cls_of(bus.DataIn), bus.DataIn});
          exp_cnt = exp_cnt + 1'b1;
        end else begin
          drop = 1'b1;
          exp_ovf = 1'b1;
        end
      end
      if (bus.clr_ovf && !drop) exp_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("level", 34'(bus.level), 34'(q.size()));
    chk("out_valid", 34'(bus.out_valid), 34'(q.size() != 0));
    chk("overflow", 34'(bus.overflow), 34'(exp_ovf));
    chk("sample_cnt", 34'(bus.sample_cnt), 34'(exp_cnt));
    if (q.size() != 0) begin
      chk("head_data", 34'(bus.out_data), 34'(q[0][31:0]));
`ifdef INVSQRT_FIFO_CLASS_EN
      chk("head_class", 34'(bus.out_class), 34'(q[0][33:32]));
`endif
    end
  endtask

  task automatic cyc(input logic c, input logic v, input logic [31:0] d, input logic r, input logic k);
    bus.ce = c;
    bus.DataValid = v;
    bus.DataIn = d;
    bus.out_ready = r;
    bus.clr_ovf = k;
    step();
  endtask

  initial begin
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    chk("rst_level", 34'(bus.level), 34'd0);
    chk("rst_cnt", 34'(bus.sample_cnt), 34'd0);
    cyc(1, 1, 32'h3F000000, 0, 0);
    chk("single_data", 34'(bus.out_data), 34'h3F000000);
    chk("single_valid", 34'(bus.out_valid), 34'd1);
    cyc(0, 0, 0, 1, 0);
    chk("single_empty", 34'(bus.out_valid), 34'd0);
    for (int i = 1; i <= 17; i++) cyc(1, 1, 32'(i), 0, 0);
    chk("full_level", 34'(bus.level), 34'd16);
    chk("full_ovf", 34'(bus.overflow), 34'd1);
    chk("full_cnt", 34'(bus.sample_cnt), 34'd17);
    for (int i = 1; i <= 16; i++) begin
      chk("drain_order", 34'(bus.out_data), 34'(i));
      cyc(0, 0, 0, 1, 0);
    end
    chk("drain_level", 34'(bus.level), 34'd0);
    chk("drain_last", 34'(bus.out_data), 34'd16);
    cyc(0, 0, 0, 0, 1);
    chk("clr_ovf", 34'(bus.overflow), 34'd0);
    for (int i = 0; i < 16; i++) cyc(1, 1, 32'h100 + 32'(i), 0, 0);
    for (int i = 0; i < 40; i++) cyc(1, 1, 32'h200 + 32'(i), 1, 0);
    chk("stream_level", 34'(bus.level), 34'd16);
    chk("stream_ovf", 34'(bus.overflow), 34'd0);
    chk("stream_cnt", 34'(bus.sample_cnt), 34'd73);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'h300 + 32'(i), 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 32'hDEAD0000 + 32'(i), 1, 0);
    chk("ce_level", 34'(bus.level), 34'd0);
    chk("ce_cnt", 34'(bus.sample_cnt), 34'd76);
    for (int i = 0; i < 16; i++) cyc(1, 1, 32'h400 + 32'(i), 0, 0);
    cyc(1, 1, 32'h4FF, 0, 1);
    chk("set_wins", 34'(bus.overflow), 34'd1);
    cyc(0, 0, 0, 0, 1);
    chk("clr_after", 34'(bus.overflow), 34'd0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
    for (int i = 0; i < 17; i++) cyc(0, 0, 0, 1, 0);
    chk("rand_drained", 34'(bus.level), 34'd0);
`ifdef INVSQRT_FIFO_CLASS_EN
    cyc(1, 1, 32'h00000000, 0, 0);
    chk("class_zero", 34'(bus.out_class), 34'b01);
    cyc(1, 1, 32'h7F800000, 0, 0);
    cyc(1, 1, 32'h7FC00000, 0, 0);
    cyc(1, 1, 32'h3F800000, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("class_inf", 34'(bus.out_class), 34'b10);
    cyc(0, 0, 0, 1, 0);
    chk("class_nan", 34'(bus.out_class), 34'b11);
    rst = 1'b0;
    cyc(1, 1, 32'h7F800001, 1, 0);
    chk("class_rst", 34'(bus.out_class), 34'b00);
    chk("class_rst_level", 34'(bus.level), 34'd0);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/invsqrt_result_fifo.md
Name: invsqrt_result_fifo

Overview:
- Downstream stage of the InvertSQRoot pipeline.
- Captures each 32-bit IEEE-754 result presented with DataValid and buffers it in a first-word-fall-through FIFO.
- Hands results to a consumer over a valid/ready interface, decoupling consumer stalls from the free-running inverse-square-root pipeline.
- Reports fill level, a sticky overflow flag and a running count of captured samples.

Parameters:
- DEPTH, 16, number of result entries; must be a power of two, at least 2.
- CNT_W, 16, width of the captured-sample counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-low; reset applies when rst=0 at a rising clk edge.
- ce  input  1  clock enable shared with InvertSQRoot; gates the write side only.
- DataIn  input  32  result word, driven by InvertSQRoot DataOut.
- DataValid  input  1  result qualifier, driven by InvertSQRoot DataValid.
- clr_ovf  input  1  clears the sticky overflow flag.
- out_data  output  32  head-of-FIFO result.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  consumer accepts out_data this cycle.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky flag: a result was dropped because the FIFO was full.
- sample_cnt  output  CNT_W  number of results written into the FIFO.

Behaviour:
- Reset (rst=0 at edge): out_valid=0, out_data=0, level=0, overflow=0, sample_cnt=0, read and write pointers=0. Storage contents are don't-care. Reset overrides every other input in the same cycle.
- Write request: ce=1 && DataValid=1.
- Read: out_valid=1 && out_ready=1. The read side ignores ce.
- Write accepted when the FIFO is not full, or when it is full and a read occurs in the same cycle.
- Dropped write (request while full, no read): data discarded, overflow set to 1 next cycle, pointers and sample_cnt unchanged.
- overflow: once set, stays set until clr_ovf=1. If clr_ovf=1 and a drop happen in the same cycle, overflow stays 1 (set wins).
- Latency: write into an empty FIFO gives out_valid=1 and out_data=DataIn on the next edge. No same-cycle bypass.
- Simultaneous read and write: on an empty FIFO, only the write occurs (out_valid was 0). Otherwise both occur and level is unchanged.
- out_data: always reflects the entry at the read pointer; updates on the edge after a read to the next entry.
- out_valid: deasserts on the edge after the last entry is read, unless a write lands in that same cycle.
- level: +1 on write-only, -1 on read-only, unchanged on both or neither. It never exceeds DEPTH and never goes below 0.
- Pointers: $clog2(DEPTH) bits wide, wrapping modulo DEPTH.
- sample_cnt: increments on each accepted write; wraps from 2^CNT_W-1 to 0 with no flag.
- out_data keeps its last value while out_valid=0. The consumer must ignore it.
- Holding out_ready=1 with out_valid=0 has no effect.

Optional Feature:
- Macro: INVSQRT_FIFO_CLASS_EN.
- Defined: adds output port out_class [1:0], stored per entry with its data. Class is computed from DataIn at write time:
  - 2'b00 normal/denormal finite.
  - 2'b01 zero: exponent=0, mantissa=0.
  - 2'b10 infinity: exponent=8'hFF, mantissa=0.
  - 2'b11 NaN: exponent=8'hFF, mantissa!=0.
  - out_class follows the same timing as out_data and resets to 2'b00.
- Undefined: out_class port and its storage are absent. All other behaviour is identical.

Test Plan:
- Reset with rst=0 for 2 cycles, then release -> out_valid=0, level=0, overflow=0, sample_cnt=0.
- Single write of DataIn=32'h3F000000, DataValid=1, ce=1, out_ready=0 -> next cycle out_valid=1, out_data=32'h3F000000, level=1. Pulse out_ready -> out_valid=0, level=0.
- With DEPTH=16, out_ready=0, write 17 words 32'h00000001..32'h00000011 -> level=16, overflow=1, sample_cnt=16. Drain -> words 1..16 in order; the 17th never appears. Pulse clr_ovf -> overflow=0.
- FIFO full with out_ready=1 and continuous writes for 40 cycles -> level stays 16, overflow stays 0, sample_cnt increments by 40, output order preserved through pointer wrap.
- DataValid=1 with ce=0 for 5 cycles -> no writes, level and sample_cnt unchanged; reads of existing entries still complete.
- With INVSQRT_FIFO_CLASS_EN defined, write 32'h00000000, 32'h7F800000, 32'h7FC00000, 32'h3F800000 -> out_class sequence 01, 10, 11, 00. Assert rst=0 mid-stream -> FIFO empties and out_class=00 next cycle.
